// File: rtl/regfile_port_scheduler.sv
// Register file write-port / read-port-1 scheduler.
// Arbitrates the single write port between the post-reset clear sweep,
// pipeline writeback (always wins) and a debug transaction port, and
// borrows read port 1 for one stalled cycle to service debug reads.
//
// state  | meaning
// -------+-----------------------------------------------------------
// INIT   | clear sweep r0..r14 to zero, one register per cycle
// IDLE   | waiting for a debug request
// DBG_WR | debug write pending; waits for a free write-port cycle
// DBG_RD | read port 1 steered to the debug index for one cycle
// ACK    | one-cycle completion pulse (with error flag if rejected)
module regfile_port_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_we,
  input  logic [3:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             dbg_req,
  input  logic             dbg_wr,
  input  logic [3:0]       dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  input  logic [WIDTH-1:0] rf_rd,
  output logic             rf_we,
  output logic [3:0]       rf_wa,
  output logic [WIDTH-1:0] rf_wd,
  output logic             rf_rsel,
  output logic [3:0]       rf_ra,
  output logic             stall,
  output logic             dbg_ack,
  output logic             dbg_err,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic             init_done
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_DBG_WR = 3'd2,
    S_DBG_RD = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [2:0]       r_blk;
  logic             r_ack;
  logic             r_err;
  logic             r_init_done;
  logic [WIDTH-1:0] r_rdata;

  logic w_init_we;
  logic w_dbg_wr_go;

  // The sweep write is qualified by reset so the port stays quiet while
  // reset is held, even though the state register already sits in INIT.
  assign w_init_we   = (r_state == S_INIT) && reset;
  assign w_dbg_wr_go = (r_state == S_DBG_WR) && !wb_we && (dbg_addr != 4'hF);

  // Main sequencer: sweep, debug request dispatch, writeback blocking, ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_INIT;
      r_cnt       <= 4'd0;
      r_blk       <= 3'd0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_init_done <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_cnt == 4'd14) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_IDLE: begin
          if (dbg_req) begin
            r_state <= dbg_wr ? S_DBG_WR : S_DBG_RD;
          end
        end
        S_DBG_WR: begin
          // r15 is protected: reject immediately, no write is attempted.
          if (dbg_addr == 4'hF) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            r_blk   <= 3'd0;
          end else if (wb_we) begin
            if (r_blk != 3'd7) begin
              r_blk <= r_blk + 3'd1;
            end
          end else begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            r_blk   <= 3'd0;
          end
        end
        S_DBG_RD: begin
          r_rdata <= rf_rd;
          r_state <= S_ACK;
          r_ack   <= 1'b1;
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

  // Write port mux: sweep, then pipeline writeback, then pending debug write.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = 4'd0;
    rf_wd = '0;
    if (w_init_we) begin
      rf_we = 1'b1;
      rf_wa = r_cnt;
      rf_wd = '0;
    end else if ((r_state != S_INIT) && wb_we) begin
      rf_we = 1'b1;
      rf_wa = wb_addr;
      rf_wd = wb_data;
    end else if (w_dbg_wr_go) begin
      rf_we = 1'b1;
      rf_wa = dbg_addr;
      rf_wd = dbg_wdata;
    end
  end

  // Stall and read-port steering decoded from registered state only.
  always_comb begin
    stall   = 1'b0;
    rf_rsel = 1'b0;
    rf_ra   = 4'd0;
    case (r_state)
      S_INIT:   stall = 1'b1;
      S_DBG_RD: begin
        stall   = 1'b1;
        rf_rsel = 1'b1;
        rf_ra   = dbg_addr;
      end
      S_DBG_WR: stall = (r_blk >= 3'd4);
      default:  stall = 1'b0;
    endcase
  end

  assign dbg_ack   = r_ack;
  assign dbg_err   = r_err;
  assign dbg_rdata = r_rdata;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Scoreboard bench for regfile_port_scheduler: a driver issues random
// writeback traffic and debug transactions, pushing expected write-port
// activity, acks and stall/steer values; a negedge monitor pops and checks.
module tb_regfile_port_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wb_we = 1'b0;
  logic [3:0] wb_addr = 4'd0;
  logic [7:0] wb_data = 8'd0;
  logic       dbg_req = 1'b0;
  logic       dbg_wr = 1'b0;
  logic [3:0] dbg_addr = 4'd0;
  logic [7:0] dbg_wdata = 8'd0;
  logic [7:0] rf_rd;
  logic       rf_we;
  logic [3:0] rf_wa;
  logic [7:0] rf_wd;
  logic       rf_rsel;
  logic [3:0] rf_ra;
  logic       stall;
  logic       dbg_ack;
  logic       dbg_err;
  logic [7:0] dbg_rdata;
  logic       init_done;

  regfile_port_scheduler #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_rsel(rf_rsel), .rf_ra(rf_ra), .stall(stall),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file storage; r15 has a known power-up value since it is never swept.
  logic [7:0] mem [16];
  logic [3:0] dec_addr = 4'd0;
  bit         seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 15) ? 8'h5A : 8'(i * 37 + 1);
      seeded <= 1'b1;
    end else if (rf_we) begin
      mem[rf_wa] <= rf_wd;
    end
  end
  assign rf_rd = rf_rsel ? mem[rf_ra] : mem[dec_addr];

  typedef struct { int cyc; logic [3:0] a; logic [7:0] d; } wr_t;
  typedef struct { int cyc; logic err; logic [7:0] rd; } ack_t;
  typedef struct { int cyc; logic s; logic r; } st_t;

  wr_t  wr_q [$];
  ack_t ack_q [$];
  st_t  st_q [$];

  logic [7:0] ref_rf [16];
  logic [7:0] last_rd = 8'h00;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic miss(input string name, input int want_cyc);
    total++;
    bad++;
    $display("FAIL %s cyc=%0d got=nothing want=event at cyc %0d", name, cyc, want_cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents write/ack activity.
  initial begin
    wr_t w;
    ack_t a;
    st_t s;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (rf_we) begin
          if (wr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write cyc=%0d got=addr %0d data %0h want=no write", cyc, rf_wa, rf_wd);
          end else begin
            w = wr_q.pop_front();
            chk("wr_cyc", cyc, w.cyc);
            chk("wr_addr", 32'(rf_wa), 32'(w.a));
            chk("wr_data", 32'(rf_wd), 32'(w.d));
          end
        end else begin
          chk("idle_wport_zero", 32'({rf_wa, rf_wd}), 32'd0);
          if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
            w = wr_q.pop_front();
            miss("missing_write", w.cyc);
          end
        end
        if (dbg_ack) begin
          if (ack_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack cyc=%0d got=ack want=no ack", cyc);
          end else begin
            a = ack_q.pop_front();
            chk("ack_cyc", cyc, a.cyc);
            chk("ack_err", 32'(dbg_err), 32'(a.err));
            chk("ack_rdata", 32'(dbg_rdata), 32'(a.rd));
          end
        end else begin
          chk("err_without_ack", 32'(dbg_err), 32'd0);
          if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
            a = ack_q.pop_front();
            miss("missing_ack", a.cyc);
          end
        end
        while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
          s = st_q.pop_front();
          miss("stale_stall_expect", s.cyc);
        end
        if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
          s = st_q.pop_front();
          chk("stall", 32'(stall), 32'(s.s));
          chk("rf_rsel", 32'(rf_rsel), 32'(s.r));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    dec_addr = 4'($urandom);
  endtask

  task automatic push_st(input logic s, input logic r);
    st_q.push_back(st_t'{cyc, s, r});
  endtask

  // Drive one cycle of pipeline writeback; every writeback must appear unchanged.
  task automatic drive_wb(input logic we);
    wb_we   = we;
    wb_addr = 4'($urandom);
    wb_data = 8'($urandom);
    if (we) begin
      wr_q.push_back(wr_t'{cyc, wb_addr, wb_data});
      ref_rf[wb_addr] = wb_data;
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      dbg_req = 1'b0;
      push_st(1'b0, 1'b0);
      drive_wb(1'($urandom));
      step();
    end
  endtask

  // Release reset at the start of the current cycle and expect the 15-cycle sweep.
  task automatic release_and_init();
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) step();
      wr_q.push_back(wr_t'{cyc, 4'(i), 8'h00});
      push_st(1'b1, 1'b0);
      wb_we     = 1'($urandom);
      wb_addr   = 4'($urandom);
      wb_data   = 8'($urandom);
      dbg_req   = 1'($urandom);
      dbg_wr    = 1'($urandom);
      dbg_addr  = 4'($urandom);
      dbg_wdata = 8'($urandom);
    end
    chk("init_done_during_sweep", 32'(init_done), 32'd0);
    step();
    chk("init_done_after_sweep", 32'(init_done), 32'd1);
    for (int r = 0; r < 15; r++) ref_rf[r] = 8'h00;
    dbg_req = 1'b0;
    push_st(1'b0, 1'b0);
    drive_wb(1'($urandom));
    step();
  endtask

  // One debug transaction; called at the start of an IDLE cycle.
  task automatic do_txn(input logic wr, input logic [3:0] addr, input logic [7:0] wd, input int nblk);
    int n;
    logic [7:0] rd;
    n = cyc;
    dbg_req   = 1'b1;
    dbg_wr    = wr;
    dbg_addr  = addr;
    dbg_wdata = wd;
    push_st(1'b0, 1'b0);
    drive_wb(1'($urandom));
    if (wr && addr != 4'hF) begin
      ack_q.push_back(ack_t'{n + nblk + 2, 1'b0, last_rd});
      for (int i = 1; i <= nblk; i++) begin
        step();
        push_st(i >= 5, 1'b0);
        drive_wb(1'b1);
      end
      step();
      drive_wb(1'b0);
      wr_q.push_back(wr_t'{cyc, addr, wd});
      ref_rf[addr] = wd;
    end else if (wr) begin
      ack_q.push_back(ack_t'{n + 2, 1'b1, last_rd});
      step();
      push_st(1'b0, 1'b0);
      drive_wb(1'b0);
    end else begin
      step();
      rd = ref_rf[addr];
      last_rd = rd;
      ack_q.push_back(ack_t'{n + 2, 1'b0, rd});
      push_st(1'b1, 1'b1);
      drive_wb(1'($urandom));
    end
    step();
    push_st(1'b0, 1'b0);
    drive_wb(1'($urandom));
    step();
  endtask

  initial begin
    int kind;
    int nb;
    for (int i = 0; i < 16; i++) ref_rf[i] = 8'h00;
    ref_rf[15] = 8'h5A;

    // Reset values, with writeback and debug inputs active to prove they are ignored.
    wb_we = 1'b1;
    wb_addr = 4'd6;
    wb_data = 8'hEE;
    dbg_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    chk("rst_dbg_err", 32'(dbg_err), 32'd0);
    chk("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
    chk("rst_rf_rsel", 32'(rf_rsel), 32'd0);
    step();
    release_and_init();

    // Directed scenarios.
    do_txn(1'b1, 4'd3, 8'hA5, 0);
    do_txn(1'b1, 4'd5, 8'h77, 6);
    idle_cycles(1);
    do_txn(1'b1, 4'd7, 8'h3C, 0);
    do_txn(1'b0, 4'd7, 8'h00, 0);
    do_txn(1'b1, 4'hF, 8'hC3, 0);
    do_txn(1'b0, 4'hF, 8'h00, 0);
    do_txn(1'b1, 4'd2, 8'h81, 11);
    do_txn(1'b0, 4'd2, 8'h00, 0);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 9);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 11) : $urandom_range(0, 2);
      do_txn(kind < 5, 4'($urandom), 8'($urandom), nb);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset during a blocked debug write: transaction aborts, sweep restarts at r0.
    dbg_req   = 1'b1;
    dbg_wr    = 1'b1;
    dbg_addr  = 4'd9;
    dbg_wdata = 8'h99;
    push_st(1'b0, 1'b0);
    drive_wb(1'b0);
    for (int i = 1; i <= 6; i++) begin
      step();
      push_st(i >= 5, 1'b0);
      drive_wb(1'b1);
    end
    step();
    reset = 1'b0;
    wr_q.delete();
    ack_q.delete();
    st_q.delete();
    wb_we = 1'b1;
    wb_addr = 4'd4;
    wb_data = 8'h44;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_rf_we", 32'(rf_we), 32'd0);
      chk("abort_dbg_ack", 32'(dbg_ack), 32'd0);
      chk("abort_stall", 32'(stall), 32'd1);
      chk("abort_init_done", 32'(init_done), 32'd0);
      step();
    end
    last_rd = 8'h00;
    release_and_init();
    do_txn(1'b0, 4'd9, 8'h00, 0);
    do_txn(1'b0, 4'hF, 8'h00, 0);
    for (int t = 0; t < 20; t++) begin
      do_txn(1'($urandom), 4'($urandom), 8'($urandom), $urandom_range(0, 6));
    end
    idle_cycles(4);

    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    chk("st_q_drained", 32'(st_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_port_scheduler.md
REGFILE_PORT_SCHEDULER -- requirements
Module: regfile_port_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the register data width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 asserts).
REQ-004 SHALL have port wb_we  input  1  pipeline writeback enable (RegWriteW).
REQ-005 SHALL have port wb_addr  input  4  pipeline writeback register index.
REQ-006 SHALL have port wb_data  input  WIDTH  pipeline writeback data.
REQ-007 SHALL have port dbg_req  input  1  debug transaction request, held until dbg_ack.
REQ-008 SHALL have port dbg_wr  input  1  1=debug write, 0=debug read.
REQ-009 SHALL have port dbg_addr  input  4  debug register index.
REQ-010 SHALL have port dbg_wdata  input  WIDTH  debug write data.
REQ-011 SHALL have port rf_rd  input  WIDTH  register file read-port-1 data.
REQ-012 SHALL have port rf_we  output  1  register file write enable.
REQ-013 SHALL have port rf_wa  output  4  register file write index.
REQ-014 SHALL have port rf_wd  output  WIDTH  register file write data.
REQ-015 SHALL have port rf_rsel  output  1  1 = steer read port 1 to rf_ra instead of decode.
REQ-016 SHALL have port rf_ra  output  4  debug read index.
REQ-017 SHALL have port stall  output  1  freezes fetch/decode.
REQ-018 SHALL have port dbg_ack  output  1  one-cycle transaction-complete pulse.
REQ-019 SHALL have port dbg_err  output  1  pulses with dbg_ack on a rejected transaction.
REQ-020 SHALL have port dbg_rdata  output  WIDTH  registered debug read result.
REQ-021 SHALL have port init_done  output  1  high once register clear sweep completes.

Function
REQ-022 SHALL implement FSM states INIT, IDLE, DBG_WR, DBG_RD, ACK.
REQ-023 INIT: 4-bit counter cnt from 0 to 14, one per cycle; rf_we=1, rf_wa=cnt, rf_wd=0, stall=1; dbg_req and wb_we ignored; r15 never written.
REQ-024 INIT SHALL exit to IDLE after the cnt=14 cycle (15 cycles total); init_done goes high the cycle IDLE is entered and stays high until reset.
REQ-025 Outside INIT, when wb_we=1 the write port SHALL carry wb_we/wb_addr/wb_data unmodified; pipeline writeback is never delayed or dropped.
REQ-026 IDLE: dbg_req=1 with dbg_wr=1 -> DBG_WR; with dbg_wr=0 -> DBG_RD; else stay IDLE.
REQ-027 DBG_WR with dbg_addr=15: no write; go to ACK with dbg_err=1.
REQ-028 DBG_WR with wb_we=0: rf_we=1, rf_wa=dbg_addr, rf_wd=dbg_wdata for that cycle; next state ACK.
REQ-029 DBG_WR with wb_we=1: stay in DBG_WR; 3-bit block counter increments (saturating); at counter >=4, stall=1 (registered) until the debug write issues; counter cleared on leaving DBG_WR.
REQ-030 DBG_RD: exactly one cycle with stall=1, rf_rsel=1, rf_ra=dbg_addr; dbg_rdata loads rf_rd at the closing edge; next state ACK; r15 reads are permitted.
REQ-031 ACK: dbg_ack=1 (dbg_err per REQ-027) for one cycle; dbg_req ignored; next state IDLE.
REQ-032 Minimum debug latency: request seen in IDLE cycle n -> access in cycle n+1 -> dbg_ack in cycle n+2.
REQ-033 dbg_rdata SHALL hold its value until the next DBG_RD capture.
REQ-034 In IDLE/ACK and unblocked DBG_WR: stall=0, rf_rsel=0.
REQ-035 When no source writes, rf_we=0, rf_wa=0, rf_wd=0.

Reset
REQ-036 While reset=0: state=INIT, cnt=0, block counter=0, rf_we=0, stall=1, init_done=0, dbg_ack=0, dbg_err=0, dbg_rdata=0, rf_rsel=0.
REQ-037 Reset asserted mid-transaction SHALL abort it with no dbg_ack and restart INIT from cnt=0 on release.

Verification
REQ-038 Release reset -> rf_we=1 writing r0..r14 with 0 over 15 cycles, stall=1 throughout, init_done=1 on cycle 16.
REQ-039 IDLE, wb_we=0, debug write r3=0xA5 -> rf_we/rf_wa=3/rf_wd=0xA5 at n+1, dbg_ack at n+2, dbg_err=0.
REQ-040 Debug write r5 while wb_we=1 for 6 cycles -> writebacks pass unchanged, stall=1 from 5th blocked cycle, debug write issues first wb_we=0 cycle, then ack.
REQ-041 Debug read r7 holding 0x3C -> stall=1 and rf_rsel=1 one cycle, dbg_ack next cycle with dbg_rdata=0x3C.
REQ-042 Debug write r15 -> no rf_we from debug, dbg_ack=1 with dbg_err=1.
REQ-043 Reset asserted during DBG_WR block -> no ack, rf_we=0, INIT sweep restarts at r0 on release.
